// File: rtl/inst_buffer.sv
// Circular instruction buffer between fetch and decode: multi-lane compacting push, multi-lane head read, flush.
// Optional IB_STATS_EN adds saturating full/empty cycle counters.
module inst_buffer #(
  parameter int DEPTH          = 8,
  parameter int FETCH_WIDTH    = 2,
  parameter int DISPATCH_WIDTH = 2,
  parameter int INST_W         = 32,
  parameter int PC_W           = 32,
  parameter int CNT_W          = $clog2(DEPTH + 1),
  parameter int DATA_W         = INST_W + PC_W + 1
) (
  input  logic                                     clock,
  input  logic                                     reset_n,
  input  logic                                     flush,
  input  logic [FETCH_WIDTH-1:0]                   fetch_valid,
  input  logic [FETCH_WIDTH-1:0][DATA_W-1:0]       fetch_packets,
  input  logic [CNT_W-1:0]                         num_dispatch,
  output logic [DISPATCH_WIDTH-1:0][DATA_W-1:0]    ib_packets,
  output logic [DISPATCH_WIDTH-1:0]                ib_valid,
  output logic [CNT_W-1:0]                         ib_count,
  output logic [CNT_W-1:0]                         ib_free_slots,
  output logic                                     ib_overflow
`ifdef IB_STATS_EN
  ,
  output logic [31:0]                              ib_full_cycles,
  output logic [31:0]                              ib_empty_cycles
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] DISP_MAX = CNT_W'(DISPATCH_WIDTH);

  function automatic logic [CNT_W-1:0] min_cnt(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic [CNT_W-1:0]  free_slots;
  logic [CNT_W-1:0]  num_req;
  logic [CNT_W-1:0]  accepted;
  logic [CNT_W-1:0]  pops;
  logic [CNT_W-1:0]  rank    [FETCH_WIDTH];
  logic [PTR_W-1:0]  wr_idx  [FETCH_WIDTH];
  logic [FETCH_WIDTH-1:0] lane_wr;

  // Push/pop sizing uses start-of-cycle occupancy; slots freed by pops are not reusable this cycle.
  always_comb begin
    free_slots = DEPTH_C - count;
    num_req    = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      rank[i]    = num_req;
      num_req    = num_req + CNT_W'(fetch_valid[i]);
    end
    accepted = min_cnt(num_req, free_slots);
    pops     = min_cnt(min_cnt(num_dispatch, count), DISP_MAX);
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      wr_idx[i]  = tail + PTR_W'(rank[i]);
      lane_wr[i] = fetch_valid[i] && (rank[i] < accepted);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      ib_overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (lane_wr[i]) mem[wr_idx[i]] <= fetch_packets[i];
      end
      head  <= head + PTR_W'(pops);
      tail  <= tail + PTR_W'(accepted);
      count <= count + accepted - pops;
      if (num_req > free_slots) ib_overflow <= 1'b1;
    end
  end

  // Outputs come only from registered state, so reset clears them without waiting for a clock.
  always_comb begin
    ib_count      = count;
    ib_free_slots = free_slots;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      ib_valid[i]   = (CNT_W'(i) < count);
      ib_packets[i] = mem[head + PTR_W'(i)];
    end
  end

`ifdef IB_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ib_full_cycles  <= '0;
      ib_empty_cycles <= '0;
    end else begin
      if (count == DEPTH_C) ib_full_cycles  <= sat_inc(ib_full_cycles);
      if (count == '0)      ib_empty_cycles <= sat_inc(ib_empty_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_inst_buffer.sv
// Bench for inst_buffer: hand-computed vector table, multi-cycle corner sequences and a queue-based random model.
module tb_inst_buffer;
  localparam int DEPTH = 8;
  localparam int FW    = 2;
  localparam int DW    = 2;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PKT_W = 65;

  logic                     clock = 1'b0;
  logic                     reset_n;
  logic                     flush;
  logic [FW-1:0]            fetch_valid;
  logic [FW-1:0][PKT_W-1:0] fetch_packets;
  logic [CNT_W-1:0]         num_dispatch;
  logic [DW-1:0][PKT_W-1:0] ib_packets;
  logic [DW-1:0]            ib_valid;
  logic [CNT_W-1:0]         ib_count;
  logic [CNT_W-1:0]         ib_free_slots;
  logic                     ib_overflow;
`ifdef IB_STATS_EN
  logic [31:0]              ib_full_cycles;
  logic [31:0]              ib_empty_cycles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  inst_buffer #(.DEPTH(DEPTH), .FETCH_WIDTH(FW), .DISPATCH_WIDTH(DW)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .flush         (flush),
    .fetch_valid   (fetch_valid),
    .fetch_packets (fetch_packets),
    .num_dispatch  (num_dispatch),
    .ib_packets    (ib_packets),
    .ib_valid      (ib_valid),
    .ib_count      (ib_count),
    .ib_free_slots (ib_free_slots),
    .ib_overflow   (ib_overflow)
`ifdef IB_STATS_EN
    ,
    .ib_full_cycles  (ib_full_cycles),
    .ib_empty_cycles (ib_empty_cycles)
`endif
  );

  // Packet layout {inst, pc, taken}; inst and taken are derived from pc so a single number identifies it.
  function automatic logic [PKT_W-1:0] mk(input logic [31:0] pc);
    return {pc ^ 32'hA5A5_0000, pc, pc[2]};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic [FW-1:0] fv, input logic [PKT_W-1:0] p0,
                       input logic [PKT_W-1:0] p1, input int nd);
    flush            = fl;
    fetch_valid      = fv;
    fetch_packets[0] = p0;
    fetch_packets[1] = p1;
    num_dispatch     = CNT_W'(nd);
  endtask

  task automatic apply_reset();
    drive(1'b0, '0, '0, '0, 0);
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"}, ib_count, 0);
    chk({tag, "_free"}, ib_free_slots, DEPTH);
    chk({tag, "_valid"}, ib_valid, 0);
    chk({tag, "_ovf"}, ib_overflow, 0);
    chk({tag, "_pkts"}, ib_packets, 0);
`ifdef IB_STATS_EN
    chk({tag, "_full_cyc"}, ib_full_cycles, 0);
    chk({tag, "_empty_cyc"}, ib_empty_cycles, 0);
`endif
  endtask

  typedef struct {
    logic        fl;
    logic [1:0]  fv;
    logic [31:0] pc0;
    logic [31:0] pc1;
    int          nd;
    int          cnt;
    logic [1:0]  vld;
    logic [31:0] lane0_pc;
    logic        ovf;
  } vec_t;

  vec_t tbl [12];
  logic [PKT_W-1:0] q [$];
  logic model_ovf;

  initial begin
    // fill 2/cycle, full push+pop, pop 1 to occupancy 5, flush, sparse lane, clamped pops
    tbl[0]  = '{1'b0, 2'b11, 32'h1000, 32'h1004, 0, 2, 2'b11, 32'h1000, 1'b0};
    tbl[1]  = '{1'b0, 2'b11, 32'h1008, 32'h100c, 0, 4, 2'b11, 32'h1000, 1'b0};
    tbl[2]  = '{1'b0, 2'b11, 32'h1010, 32'h1014, 0, 6, 2'b11, 32'h1000, 1'b0};
    tbl[3]  = '{1'b0, 2'b11, 32'h1018, 32'h101c, 0, 8, 2'b11, 32'h1000, 1'b0};
    tbl[4]  = '{1'b0, 2'b11, 32'h2000, 32'h2004, 2, 6, 2'b11, 32'h1008, 1'b1};
    tbl[5]  = '{1'b0, 2'b00, 32'h0,    32'h0,    1, 5, 2'b11, 32'h100c, 1'b1};
    tbl[6]  = '{1'b1, 2'b11, 32'h3000, 32'h3004, 1, 0, 2'b00, 32'h0,    1'b1};
    tbl[7]  = '{1'b0, 2'b10, 32'h0,    32'h100,  0, 1, 2'b01, 32'h100,  1'b1};
    tbl[8]  = '{1'b0, 2'b00, 32'h0,    32'h0,    2, 0, 2'b00, 32'h0,    1'b1};
    tbl[9]  = '{1'b0, 2'b01, 32'h200,  32'h0,    0, 1, 2'b01, 32'h200,  1'b1};
    tbl[10] = '{1'b0, 2'b11, 32'h300,  32'h304,  7, 2, 2'b11, 32'h300,  1'b1};
    tbl[11] = '{1'b0, 2'b00, 32'h0,    32'h0,    9, 0, 2'b00, 32'h0,    1'b1};

    reset_n = 1'b0;
    apply_reset();
    chk_reset_vals("reset");

    for (int v = 0; v < 12; v++) begin
      drive(tbl[v].fl, tbl[v].fv, mk(tbl[v].pc0), mk(tbl[v].pc1), tbl[v].nd);
      @(posedge clock);
      #1;
      chk($sformatf("vec%0d_count", v), ib_count, tbl[v].cnt);
      chk($sformatf("vec%0d_free", v), ib_free_slots, DEPTH - tbl[v].cnt);
      chk($sformatf("vec%0d_valid", v), ib_valid, tbl[v].vld);
      chk($sformatf("vec%0d_ovf", v), ib_overflow, tbl[v].ovf);
      if (tbl[v].cnt > 0) chk($sformatf("vec%0d_lane0", v), ib_packets[0], mk(tbl[v].lane0_pc));
    end

    // Async reset in the middle of a burst: outputs clear before the next edge.
    drive(1'b0, 2'b11, mk(32'h4000), mk(32'h4004), 0);
    @(posedge clock);
    #1 drive(1'b0, 2'b11, mk(32'h4008), mk(32'h400c), 0);
    chk("burst_count", ib_count, 2);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    @(negedge clock);
    reset_n = 1'b1;
    drive(1'b0, '0, '0, '0, 0);

    // Wrap-around: push 2 / pop 2 with sequential PCs for 20 cycles.
    apply_reset();
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 2'b11, mk(32'(8 * k)), mk(32'(8 * k + 4)), 2);
      @(posedge clock);
      #1;
      chk($sformatf("wrap%0d_count", k), ib_count, 2);
      chk($sformatf("wrap%0d_lane0", k), ib_packets[0], mk(32'(8 * k)));
      chk($sformatf("wrap%0d_lane1", k), ib_packets[1], mk(32'(8 * k + 4)));
    end
    chk("wrap_ovf", ib_overflow, 0);

    // Random traffic against a queue model.
    apply_reset();
    q.delete();
    model_ovf = 1'b0;
    for (int c = 0; c < 600; c++) begin
      logic             fl;
      logic [FW-1:0]    fv;
      logic [PKT_W-1:0] p [FW];
      int               nd;
      int               free;
      int               pops;
      int               nreq;
      int               nvis;
      logic [PKT_W-1:0] acc [$];
      fl = ($urandom_range(0, 29) == 0);
      fv = FW'($urandom);
      for (int i = 0; i < FW; i++) p[i] = {$urandom, $urandom, 1'($urandom)};
      nd = $urandom_range(0, 9);
      drive(fl, fv, p[0], p[1], nd);
      if (fl) begin
        q.delete();
      end else begin
        free = DEPTH - q.size();
        pops = nd;
        if (pops > q.size()) pops = q.size();
        if (pops > DW) pops = DW;
        nreq = 0;
        acc.delete();
        for (int i = 0; i < FW; i++) begin
          if (fv[i]) begin
            if (nreq < free) acc.push_back(p[i]);
            nreq++;
          end
        end
        if (nreq > free) model_ovf = 1'b1;
        for (int i = 0; i < pops; i++) void'(q.pop_front());
        foreach (acc[i]) q.push_back(acc[i]);
      end
      @(posedge clock);
      #1;
      nvis = (q.size() < DW) ? q.size() : DW;
      chk($sformatf("rnd%0d_count", c), ib_count, q.size());
      chk($sformatf("rnd%0d_free", c), ib_free_slots, DEPTH - q.size());
      chk($sformatf("rnd%0d_valid", c), ib_valid, (1 << nvis) - 1);
      chk($sformatf("rnd%0d_ovf", c), ib_overflow, model_ovf);
      for (int i = 0; i < nvis; i++) chk($sformatf("rnd%0d_lane%0d", c, i), ib_packets[i], q[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
